// File: rtl/pulse_stretcher.sv
// Widens a single-cycle trigger into a high level of programmable length,
// followed by a forced low gap before the next trigger can be accepted.
//
// state | meaning
// IDLE  | waiting for a trigger; out low
// HIGH  | stretched pulse active; cnt holds remaining high cycles
// HOLD  | enforced low gap; cnt holds remaining gap cycles, triggers dropped
module pulse_stretcher #(
    parameter int W         = 8,
    parameter int GAP       = 2,
    parameter int RETRIGGER = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trig,
    input  logic [W-1:0] len,
    output logic         out,
    output logic         busy,
    output logic         done,
    output logic         dropped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE        = W'(1);
    localparam logic [W-1:0] GAP_W      = W'(GAP);
    localparam state_t       EXIT_STATE = (GAP > 0) ? HOLD : IDLE;
    localparam bit           RELOAD_EN  = (RETRIGGER != 0);

    if (GAP < 0 || GAP > (2 ** W) - 1) begin : g_gap_check
        $error("pulse_stretcher: GAP does not fit in W bits");
    end

    state_t         state, state_nxt;
    logic [W-1:0]   cnt, cnt_nxt;
    logic           done_nxt;
    logic           dropped_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            done    <= done_nxt;
            dropped <= dropped_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dropped_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    if (len != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = len;
                    end else begin
                        dropped_nxt = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (cnt == ONE) begin
                    state_nxt = EXIT_STATE;
                    cnt_nxt   = GAP_W;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
                // A reload wins over the exit, even on the last high cycle.
                if (trig) begin
                    if (RELOAD_EN && len != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = len;
                    end else begin
                        dropped_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt <= ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
                if (trig) begin
                    dropped_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        done_nxt = (state == HIGH) && (state_nxt != HIGH);
    end

    assign out  = (state == HIGH);
    assign busy = (state != IDLE);

endmodule
